// File: rtl/pong_defs.sv
// Shared pong constants: screen geometry, paddle/ball sizes and the AI paddle FSM encodings.
package pong_defs;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 16;
    localparam int PADDLE_H  = 64;
    localparam int MAX_Y     = SCREEN_H - PADDLE_H;

    localparam logic [9:0] CENTER_Y = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [9:0] MAX_Y_U  = 10'(MAX_Y);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_TRACK  = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_RETURN = 3'd4;

    localparam logic signed [11:0] CENTRE_OFFSET = 12'(BALL_SIZE / 2 - PADDLE_H / 2);
    localparam logic signed [11:0] MAX_Y_S       = 12'(MAX_Y);

    // Aligns the paddle centre with the ball centre, then clamps so the paddle stays on screen.
    function automatic logic [9:0] clamp_target(input logic [9:0] predicted_y);
        logic signed [11:0] raw;
        raw = $signed({2'b00, predicted_y}) + CENTRE_OFFSET;
        if (raw < 12'sd0)
            return 10'd0;
        else if (raw > MAX_Y_S)
            return MAX_Y_U;
        else
            return raw[9:0];
    endfunction

endpackage

// File: rtl/paddle_stepper.sv
// Combinational bounded step of a paddle toward a target; never overshoots the target.
module paddle_stepper #(
    parameter int SPEED     = 4,
    parameter int DEAD_ZONE = 1
) (
    input  logic [9:0] target,
    input  logic [9:0] current,
    output logic [9:0] next_y,
    output logic       at_target
);

    logic signed [10:0] diff;
    logic [9:0]         mag;
    logic [9:0]         step;

    always_comb begin
        diff      = $signed({1'b0, target}) - $signed({1'b0, current});
        mag       = diff[10] ? 10'(-diff) : diff[9:0];
        at_target = (mag <= 10'(DEAD_ZONE));
        step      = (mag < 10'(SPEED)) ? mag : 10'(SPEED);
        if (at_target)
            next_y = current;
        else if (diff[10])
            next_y = current - step;
        else
            next_y = current + step;
    end

endmodule

// File: rtl/ai_paddle_controller.sv
// Computer-controlled left paddle: follows the predicted impact point after a reaction
// delay, holds there for a while, then drifts back to the screen centre.
module ai_paddle_controller
    import pong_defs::*;
#(
    parameter int SPEED           = 4,
    parameter int DEAD_ZONE       = 1,
    parameter int REACTION_FRAMES = 2,
    parameter int HOLD_FRAMES     = 30
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       vsync_start_in,
    input  logic       predicted_valid_in,
    input  logic [9:0] predicted_y_in,
    output logic [9:0] paddle_y_out,
    output logic       paddle_moving_out,
    output logic [2:0] state_out
);

    // Inputs are single-cycle strobes with no back-pressure: predicted_y_in is meaningful
    // only while predicted_valid_in is high, and a valid always wins over a same-cycle vsync.

    localparam logic [7:0] REACTION_CNT = 8'(REACTION_FRAMES);
    localparam logic [7:0] HOLD_CNT     = 8'(HOLD_FRAMES);

    logic [2:0] state;
    logic [9:0] target;
    logic [9:0] paddle_y;
    logic [7:0] frame_cnt;
    logic [9:0] step_y;
    logic       at_target;

    paddle_stepper #(
        .SPEED     (SPEED),
        .DEAD_ZONE (DEAD_ZONE)
    ) u_stepper (
        .target    (target),
        .current   (paddle_y),
        .next_y    (step_y),
        .at_target (at_target)
    );

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state     <= ST_IDLE;
            target    <= CENTER_Y;
            paddle_y  <= CENTER_Y;
            frame_cnt <= 8'd0;
        end else if (predicted_valid_in) begin
            target <= clamp_target(predicted_y_in);
            // Tracking keeps its momentum; every other state restarts the reaction delay.
            if (state != ST_TRACK) begin
                frame_cnt <= REACTION_CNT;
                state     <= (REACTION_FRAMES == 0) ? ST_TRACK : ST_WAIT;
            end
        end else if (vsync_start_in) begin
            case (state)
                ST_WAIT: begin
                    if (frame_cnt <= 8'd1) begin
                        frame_cnt <= 8'd0;
                        state     <= ST_TRACK;
                    end else begin
                        frame_cnt <= frame_cnt - 8'd1;
                    end
                end
                ST_TRACK: begin
                    if (at_target) begin
                        frame_cnt <= HOLD_CNT;
                        state     <= ST_HOLD;
                    end else begin
                        paddle_y <= step_y;
                    end
                end
                ST_HOLD: begin
                    if (frame_cnt <= 8'd1) begin
                        frame_cnt <= 8'd0;
                        target    <= CENTER_Y;
                        state     <= ST_RETURN;
                    end else begin
                        frame_cnt <= frame_cnt - 8'd1;
                    end
                end
                ST_RETURN: begin
                    if (at_target)
                        state <= ST_IDLE;
                    else
                        paddle_y <= step_y;
                end
                default: begin
                end
            endcase
        end
    end

    assign paddle_y_out      = paddle_y;
    assign paddle_moving_out = (state == ST_TRACK) || (state == ST_RETURN);
    assign state_out         = state;

endmodule

// File: tb/tb_ai_paddle_controller.sv
// Directed bench for ai_paddle_controller: frame-level reference model checked every cycle,
// plus hand-computed literal expectations along the test sequence.
module tb_ai_paddle_controller;
    import pong_defs::*;

    localparam int SPEED    = 4;
    localparam int DZ       = 1;
    localparam int REACTION = 2;
    localparam int HOLD     = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs  = 1'b0;
    logic       pv  = 1'b0;
    logic [9:0] py  = 10'd0;
    logic [9:0] paddle_y;
    logic       moving;
    logic [2:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    ai_paddle_controller #(
        .SPEED           (SPEED),
        .DEAD_ZONE       (DZ),
        .REACTION_FRAMES (REACTION),
        .HOLD_FRAMES     (HOLD)
    ) dut (
        .clock_in           (clk),
        .reset_in           (rst),
        .vsync_start_in     (vs),
        .predicted_valid_in (pv),
        .predicted_y_in     (py),
        .paddle_y_out       (paddle_y),
        .paddle_moving_out  (moving),
        .state_out          (state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard helper ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int m_y      = 208;
    int m_tgt    = 208;
    int m_phase  = 0;
    int m_frames = 0;
    int m_d;
    int m_mag;

    function automatic int clamp_i(input int v);
        if (v < 0) return 0;
        if (v > SCREEN_H - PADDLE_H) return SCREEN_H - PADDLE_H;
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_y = 208; m_tgt = 208; m_phase = int'(ST_IDLE); m_frames = 0;
        end else if (pv) begin
            m_tgt = clamp_i(int'(py) + BALL_SIZE / 2 - PADDLE_H / 2);
            if (m_phase != int'(ST_TRACK)) begin
                m_frames = REACTION;
                m_phase  = (REACTION == 0) ? int'(ST_TRACK) : int'(ST_WAIT);
            end
        end else if (vs) begin
            if (m_phase == int'(ST_WAIT)) begin
                m_frames = m_frames - 1;
                if (m_frames <= 0) m_phase = int'(ST_TRACK);
            end else if (m_phase == int'(ST_HOLD)) begin
                m_frames = m_frames - 1;
                if (m_frames <= 0) begin
                    m_tgt = 208;
                    m_phase = int'(ST_RETURN);
                end
            end else if (m_phase == int'(ST_TRACK) || m_phase == int'(ST_RETURN)) begin
                m_d   = m_tgt - m_y;
                m_mag = (m_d < 0) ? -m_d : m_d;
                if (m_mag <= DZ) begin
                    if (m_phase == int'(ST_TRACK)) begin
                        m_phase = int'(ST_HOLD);
                        m_frames = HOLD;
                    end else begin
                        m_phase = int'(ST_IDLE);
                    end
                end else begin
                    if (m_mag > SPEED) m_mag = SPEED;
                    m_y = (m_d < 0) ? m_y - m_mag : m_y + m_mag;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            check("paddle_y", int'(paddle_y), m_y);
            check("state", int'(state), m_phase);
            check("moving", int'(moving),
                  (m_phase == int'(ST_TRACK) || m_phase == int'(ST_RETURN)) ? 1 : 0);
            check("paddle_y_in_range", (int'(paddle_y) <= SCREEN_H - PADDLE_H) ? 1 : 0, 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic vsync(input int n);
        repeat (n) begin
            @(negedge clk); vs = 1'b1;
            @(negedge clk); vs = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_valid(input int y);
        @(negedge clk); pv = 1'b1; py = 10'(y);
        @(negedge clk); pv = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_valid_vsync(input int y);
        @(negedge clk); pv = 1'b1; vs = 1'b1; py = 10'(y);
        @(negedge clk); pv = 1'b0; vs = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
        check("reset_y", int'(paddle_y), 208);
        check("reset_state", int'(state), int'(ST_IDLE));
        check("reset_moving", int'(moving), 0);

        vsync(5);
        check("idle_no_move", int'(paddle_y), 208);

        send_valid(100);
        check("wait_entered", int'(state), int'(ST_WAIT));
        vsync(2);
        check("track_after_delay", int'(state), int'(ST_TRACK));
        check("no_move_on_track_entry", int'(paddle_y), 208);
        vsync(1);
        check("first_step", int'(paddle_y), 204);
        vsync(31);
        check("after_32_steps", int'(paddle_y), 80);
        vsync(1);
        check("after_33_steps", int'(paddle_y), 76);
        vsync(1);
        check("hold_entered", int'(state), int'(ST_HOLD));
        vsync(29);
        check("still_hold", int'(state), int'(ST_HOLD));
        vsync(1);
        check("return_entered", int'(state), int'(ST_RETURN));
        check("return_no_move", int'(paddle_y), 76);
        vsync(1);
        check("return_first_step", int'(paddle_y), 80);
        vsync(32);
        check("return_centre", int'(paddle_y), 208);
        vsync(1);
        check("idle_after_return", int'(state), int'(ST_IDLE));
        check("idle_not_moving", int'(moving), 0);

        send_valid(0);
        vsync(2 + 52);
        check("clamp_low", int'(paddle_y), 0);
        vsync(1);
        check("clamp_low_hold", int'(state), int'(ST_HOLD));
        send_valid(470);
        check("hold_valid_to_wait", int'(state), int'(ST_WAIT));
        vsync(2 + 104);
        check("clamp_high", int'(paddle_y), 416);
        vsync(1);
        check("clamp_high_hold", int'(state), int'(ST_HOLD));

        send_valid(200);
        vsync(2 + 3);
        check("track_to_176", int'(paddle_y), 404);
        send_valid_vsync(374);
        check("same_cycle_no_step", int'(paddle_y), 404);
        check("same_cycle_still_track", int'(state), int'(ST_TRACK));
        vsync(1);
        check("step_to_new_target", int'(paddle_y), 400);

        send_valid(174);
        check("retarget_in_track", int'(state), int'(ST_TRACK));
        vsync(62);
        check("approach_150", int'(paddle_y), 152);
        vsync(1);
        check("reach_150", int'(paddle_y), 150);
        pulse_reset();
        check("midop_reset_y", int'(paddle_y), 208);
        check("midop_reset_state", int'(state), int'(ST_IDLE));
        check("midop_reset_moving", int'(moving), 0);

        send_valid(300);
        vsync(2 + 16);
        check("after_16_steps", int'(paddle_y), 272);
        vsync(1);
        check("reach_276", int'(paddle_y), 276);
        check("reach_276_track", int'(state), int'(ST_TRACK));

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
